tone_player: RTL and testbench

//   Parametrised successor to the fixed divide-by-16 speaker driver. Plays a stream of notes

---
 rtl/tone_player.sv | 106 ++++++++++
 tb/tb_tone_player.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tone_player.sv
// Note-stream square-wave speaker driver: accepts (half-period, duration) notes over
// valid/ready and plays them back-to-back with a registered, glitch-free speaker output.
module tone_player #(
  parameter int DIV_W = 20,
  parameter int DUR_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [DIV_W-1:0] note_half,
  input  logic [DUR_W-1:0] note_dur,
  output logic             speaker,
  output logic             busy,
  output logic             note_done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DIV_W-1:0]  phase_q, phase_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic              speaker_q, speaker_d;
  logic              done_q, done_d;

  logic              last;
  logic              xfer;
  logic [DUR_W-1:0]  dur_eff;

  // dur_q always holds a value >= 1 while playing, so dur_q-1 cannot wrap there
  assign last       = (state_q == S_PLAY) && (dur_cnt_q == dur_q - DUR_W'(1));
  assign note_ready = (state_q == S_IDLE) || last;
  assign xfer       = note_valid && note_ready;
  assign dur_eff    = (note_dur == '0) ? DUR_W'(1) : note_dur;

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    dur_d     = dur_q;
    phase_d   = phase_q;
    dur_cnt_d = dur_cnt_q;
    speaker_d = speaker_q;
    done_d    = 1'b0;

    if (state_q == S_PLAY) begin
      dur_cnt_d = dur_cnt_q + DUR_W'(1);
      if (half_q == '0) begin
        phase_d   = '0;
        speaker_d = 1'b0;
      end else if (phase_q == half_q - DIV_W'(1)) begin
        phase_d   = '0;
        speaker_d = ~speaker_q;
      end else begin
        phase_d = phase_q + DIV_W'(1);
      end

      // note end overrides any toggle landing on the same edge
      if (last) begin
        state_d   = S_IDLE;
        phase_d   = '0;
        dur_cnt_d = '0;
        speaker_d = 1'b0;
        done_d    = 1'b1;
      end
    end

    if (xfer) begin
      state_d   = S_PLAY;
      half_d    = note_half;
      dur_d     = dur_eff;
      phase_d   = '0;
      dur_cnt_d = '0;
      speaker_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      half_q    <= '0;
      dur_q     <= '0;
      phase_q   <= '0;
      dur_cnt_q <= '0;
      speaker_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      dur_q     <= dur_d;
      phase_q   <= phase_d;
      dur_cnt_q <= dur_cnt_d;
      speaker_q <= speaker_d;
      done_q    <= done_d;
    end
  end

  assign speaker   = speaker_q;
  assign busy      = (state_q == S_PLAY);
  assign note_done = done_q;

endmodule

// File: tb/tb_tone_player.sv
// Scoreboard bench for tone_player: drivers push per-cycle expected outputs with a cycle
// stamp; a negedge monitor pops and compares {speaker,busy,note_done,note_ready}.
module tb_tone_player;
  localparam int DIV_W = 6;
  localparam int DUR_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             note_valid;
  logic             note_ready;
  logic [DIV_W-1:0] note_half;
  logic [DUR_W-1:0] note_dur;
  logic             speaker;
  logic             busy;
  logic             note_done;

  tone_player #(.DIV_W(DIV_W), .DUR_W(DUR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_half  (note_half),
    .note_dur   (note_dur),
    .speaker    (speaker),
    .busy       (busy),
    .note_done  (note_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] exp;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc = cyc + 1;

  // monitor: compare every scoreboard entry stamped with the current cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      vectors = vectors + 1;
      if (e.cyc != cyc) begin
        miscompares = miscompares + 1;
        $display("FAIL t%0d stale entry: at cycle %0d, wanted cycle %0d", e.id, cyc, e.cyc);
      end else if ({speaker, busy, note_done, note_ready} !== e.exp) begin
        miscompares = miscompares + 1;
        $display("FAIL t%0d cyc %0d {spk,busy,done,ready}: got %b want %b",
                 e.id, cyc, {speaker, busy, note_done, note_ready}, e.exp);
      end
    end
  end

  task automatic push(input int c, input logic [3:0] x, input int id);
    exp_t e;
    e.cyc = c;
    e.exp = x;
    e.id  = id;
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input int c0, input int n, input int id);
    for (int i = 0; i < n; i++) push(c0 + i, 4'b0001, id);
  endtask

  // expected trace for a note accepted at the edge ending cycle n
  task automatic push_note(input int n, input int h, input int d, input bit done_first,
                           input bit tail, input int lim, input int id);
    int   de;
    logic spk;
    de = (d == 0) ? 1 : d;
    for (int k = 1; k <= de; k++) begin
      if (k <= lim) begin
        spk = (h == 0) ? 1'b0 : 1'(((k - 1) / h) % 2);
        push(n + k, {spk, 1'b1, (k == 1) && done_first, k == de}, id);
      end
    end
    if (tail) push(n + de + 1, 4'b0011, id);
  endtask

  task automatic send(input int h, input int d, input int id, input bit idle_after);
    int n;
    int de;
    @(negedge clk);
    note_valid = 1'b1;
    note_half  = DIV_W'(h);
    note_dur   = DUR_W'(d);
    n  = cyc;
    de = (d == 0) ? 1 : d;
    push_note(n, h, d, 1'b0, 1'b1, 1 << 30, id);
    if (idle_after) push_idle(n + de + 2, 2, id);
    @(posedge clk);
    #1 note_valid = 1'b0;
  endtask

  task automatic drain(input int id);
    int t;
    t = 0;
    while (sb_q.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() > 0) begin
      miscompares = miscompares + 1;
      $display("FAIL t%0d drain timeout: %0d entries left, want 0", id, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    note_valid = 1'b0;
    note_half  = '0;
    note_dur   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_idle(cyc + 1, 3, 0);
    drain(0);

    // 8-cycle half-period for 64 cycles; offer a note mid-play that must be ignored
    send(8, 64, 2, 1'b1);
    repeat (20) @(negedge clk);
    note_valid = 1'b1;
    note_half  = DIV_W'(5);
    note_dur   = DUR_W'(7);
    repeat (5) @(negedge clk);
    note_valid = 1'b0;
    drain(2);

    send(0, 10, 3, 1'b1);
    drain(3);

    // gapless pair with valid held across both notes
    @(negedge clk);
    note_valid = 1'b1;
    note_half  = DIV_W'(3);
    note_dur   = DUR_W'(12);
    n = cyc;
    push_note(n, 3, 12, 1'b0, 1'b0, 1 << 30, 4);
    push_note(n + 12, 5, 20, 1'b1, 1'b1, 1 << 30, 4);
    push_idle(n + 34, 2, 4);
    @(posedge clk);
    #1;
    note_half = DIV_W'(5);
    note_dur  = DUR_W'(20);
    repeat (12) @(posedge clk);
    #1 note_valid = 1'b0;
    drain(4);

    send(1, 0, 5, 1'b1);
    drain(5);

    // maximum half-period and duration for this width
    send((1 << DIV_W) - 1, (1 << DUR_W) - 1, 6, 1'b1);
    drain(6);

    // reset in the middle of a note: abandoned, no note_done
    @(negedge clk);
    note_valid = 1'b1;
    note_half  = DIV_W'(2);
    note_dur   = DUR_W'(50);
    n = cyc;
    push_note(n, 2, 50, 1'b0, 1'b0, 5, 1);
    push_idle(n + 6, 6, 1);
    @(posedge clk);
    #1 note_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

endmodule
